id_branch_resolver: RTL

//  Decode-stage branch resolver and predictor trainer, parametrised successor to the ID-stage Alt_PC logic.

---
 rtl/brp_pkg.sv | 38 +++
 rtl/id_branch_resolver_if.sv | 70 +++++++
 rtl/brp_pht.sv | 47 ++++
 rtl/id_branch_resolver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/brp_pkg.sv
// Shared definitions for the decode-stage branch resolver: FSM state encoding,
// 2-bit PHT counter constants, delay-slot offset and the saturating counter update.
package brp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } brp_state_e;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    localparam int DELAY_SLOT_OFFSET = 8;

    // Two-bit counter step toward the observed direction, pinned at SNT and ST.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != CNT_ST) begin
                res = cnt + 2'd1;
            end else begin
                res = cnt;
            end
        end else begin
            if (cnt != CNT_SNT) begin
                res = cnt - 2'd1;
            end else begin
                res = cnt;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/id_branch_resolver_if.sv
// Bundle between the ID stage / fetch and the branch resolver.
// Statistic counters appear only when BRP_STATS_EN is defined.
interface id_branch_resolver_if #(
    parameter int ADDR_W = 32
);
    logic              Freeze_IN;
    logic              Valid_IN;
    logic [ADDR_W-1:0] Instr_PC_IN;
    logic              Is_Branch_IN;
    logic              Is_Jump_IN;
    logic              Taken_IN;
    logic [ADDR_W-1:0] Target_IN;
    logic              Pred_Taken_IN;
    logic [ADDR_W-1:0] Pred_Target_IN;
    logic [ADDR_W-1:0] Lookup_PC_IN;
    logic              Lookup_Taken_OUT;
    logic              Request_Alt_PC;
    logic [ADDR_W-1:0] Alt_PC;
    logic              Flush_OUT;
    logic              Busy_OUT;
`ifdef BRP_STATS_EN
    logic [31:0]       Branch_Count_OUT;
    logic [31:0]       Mispredict_Count_OUT;
`endif

    modport slave (
`ifdef BRP_STATS_EN
        output Branch_Count_OUT,
        output Mispredict_Count_OUT,
`endif
        input  Freeze_IN,
        input  Valid_IN,
        input  Instr_PC_IN,
        input  Is_Branch_IN,
        input  Is_Jump_IN,
        input  Taken_IN,
        input  Target_IN,
        input  Pred_Taken_IN,
        input  Pred_Target_IN,
        input  Lookup_PC_IN,
        output Lookup_Taken_OUT,
        output Request_Alt_PC,
        output Alt_PC,
        output Flush_OUT,
        output Busy_OUT
    );

    modport master (
`ifdef BRP_STATS_EN
        input  Branch_Count_OUT,
        input  Mispredict_Count_OUT,
`endif
        output Freeze_IN,
        output Valid_IN,
        output Instr_PC_IN,
        output Is_Branch_IN,
        output Is_Jump_IN,
        output Taken_IN,
        output Target_IN,
        output Pred_Taken_IN,
        output Pred_Target_IN,
        output Lookup_PC_IN,
        input  Lookup_Taken_OUT,
        input  Request_Alt_PC,
        input  Alt_PC,
        input  Flush_OUT,
        input  Busy_OUT
    );

endinterface

// File: rtl/brp_pht.sv
// Pattern history table: 2^IDX_W two-bit counters, one asynchronous read port
// and one synchronous saturating write port; reset returns every entry to WNT.
module brp_pht
    import brp_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    // Read is combinational off the stored array, so a same-cycle write is not visible.
    always_comb begin
        rd_cnt = cnt_q[rd_idx];
    end

    // Next-state for the counter array: only the written entry moves.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = sat_update(cnt_q[wr_idx], wr_taken);
        end else begin
            cnt_d[wr_idx] = cnt_q[wr_idx];
        end
    end

    // Counter array storage.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/id_branch_resolver.sv
// Decode-stage branch resolver: detects mispredictions, issues a registered redirect
// with a bounded flush window and trains a gshare PHT. Optional stats via BRP_STATS_EN.
module id_branch_resolver
    import brp_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter int PHT_IDX_W        = 10,
    parameter int GHR_W            = 8,
    parameter int REDIRECT_BUBBLES = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    id_branch_resolver_if.slave  bus
);
    localparam int CNT_W = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;

    brp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [ADDR_W-1:0] alt_pc_q, alt_pc_d;

    logic                 resolve_s;
    logic                 taken_s;
    logic                 mispredict_s;
    logic                 train_s;
    logic [PHT_IDX_W-1:0] rd_idx_s;
    logic [PHT_IDX_W-1:0] wr_idx_s;
    logic [1:0]           rd_cnt_s;
    logic                 lookup_unused_s;

    // Resolve qualification, effective direction and misprediction compare.
    always_comb begin
        resolve_s    = bus.Valid_IN & (bus.Is_Branch_IN | bus.Is_Jump_IN)
                     & ~bus.Freeze_IN & (state_q == ST_IDLE);
        taken_s      = bus.Is_Jump_IN | bus.Taken_IN;
        mispredict_s = (taken_s != bus.Pred_Taken_IN)
                     | (taken_s & (bus.Target_IN != bus.Pred_Target_IN));
        train_s      = resolve_s & bus.Is_Branch_IN & ~bus.Is_Jump_IN;
        rd_idx_s     = bus.Lookup_PC_IN[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
        wr_idx_s     = bus.Instr_PC_IN[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
        lookup_unused_s = &{1'b0, bus.Lookup_PC_IN[1:0], bus.Lookup_PC_IN[ADDR_W-1:PHT_IDX_W+2]};
    end

    brp_pht #(
        .IDX_W (PHT_IDX_W)
    ) u_pht (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_idx   (rd_idx_s),
        .rd_cnt   (rd_cnt_s),
        .wr_en    (train_s),
        .wr_idx   (wr_idx_s),
        .wr_taken (bus.Taken_IN)
    );

    // Next-state logic for the redirect FSM and drain counter; frozen cycles hold.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (!bus.Freeze_IN) begin
            case (state_q)
                ST_IDLE: begin
                    if (resolve_s && mispredict_s) begin
                        state_d = ST_REDIRECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (REDIRECT_BUBBLES > 1) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = CNT_W'(REDIRECT_BUBBLES - 2);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Redirect target capture and history shift on a resolved conditional branch.
    always_comb begin
        alt_pc_d = alt_pc_q;
        ghr_d    = ghr_q;
        if (resolve_s && mispredict_s) begin
            alt_pc_d = taken_s ? bus.Target_IN
                               : bus.Instr_PC_IN + ADDR_W'(DELAY_SLOT_OFFSET);
        end else begin
            alt_pc_d = alt_pc_q;
        end
        if (train_s) begin
            ghr_d = GHR_W'({ghr_q, bus.Taken_IN});
        end else begin
            ghr_d = ghr_q;
        end
    end

    // State, drain counter, history and redirect address registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            ghr_q       <= '0;
            alt_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            ghr_q       <= ghr_d;
            alt_pc_q    <= alt_pc_d;
        end
    end

    // Outputs decoded straight from the registered state.
    always_comb begin
        bus.Request_Alt_PC   = (state_q == ST_REDIRECT);
        bus.Flush_OUT        = (state_q != ST_IDLE);
        bus.Busy_OUT         = (state_q != ST_IDLE);
        bus.Alt_PC           = alt_pc_q;
        bus.Lookup_Taken_OUT = rd_cnt_s[1];
    end

`ifdef BRP_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // Event counters wrap naturally at 2^32.
    always_comb begin
        branch_cnt_d = branch_cnt_q + 32'(resolve_s);
        mis_cnt_d    = mis_cnt_q + 32'(resolve_s & mispredict_s);
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            branch_cnt_q <= 32'd0;
            mis_cnt_q    <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    // Trace line per accepted misprediction.
    always_ff @(posedge CLK) begin
        if (!RESET && resolve_s && mispredict_s) begin
            $display("BRP: mispredict pc=%h redirect=%h", bus.Instr_PC_IN, alt_pc_d);
        end
    end

    always_comb begin
        bus.Branch_Count_OUT     = branch_cnt_q;
        bus.Mispredict_Count_OUT = mis_cnt_q;
    end
`endif

endmodule
